dac_serial_tx: RTL and testbench



---
 rtl/dac_serial_tx_pkg.sv | 6 +
 rtl/piso_shift_reg.sv | 18 +
 rtl/dac_serial_tx.sv | 52 +++++
 tb/tb_dac_serial_tx.sv | 81 ++++++++
 4 files changed

// File: rtl/dac_serial_tx_pkg.sv
// dac_serial_tx_pkg: shared DAC constants and serial format selector
package dac_serial_tx_pkg;
  localparam int SAMPLE_RATE = 48000;
  localparam int DAC_WIDTH = 24;
  typedef enum logic {I2S = 1'b1, LEFT_JUSTIFIED = 1'b0} dac_format_t;
endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-load, MSB-first shift register
module piso_shift_reg #(
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);
  logic [WIDTH-1:0] q;
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (load) q <= din;
    else if (shift) q <= {q[WIDTH-2:0], 1'b0};
  assign msb = q[WIDTH-1];
endmodule

// File: rtl/dac_serial_tx.sv
// dac_serial_tx: stereo parallel-to-serial I2S / left-justified DAC transmitter
module dac_serial_tx
  import dac_serial_tx_pkg::*;
#(
  parameter int WIDTH    = DAC_WIDTH,
  parameter bit I2S_MODE = bit'(I2S)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] left_data,
  input  logic [WIDTH-1:0] right_data,
  output logic             sclk,
  output logic             lrclk,
  output logic             sd,
  output logic             frame_start
);
  localparam int FRAME = 2 * WIDTH;
  localparam int CW = $clog2(FRAME);
  logic [CW-1:0] cnt, cnt_next;
  logic run, dly, msb, load, shift;
  always_comb begin
    cnt_next = (!run || cnt == CW'(FRAME - 1)) ? '0 : cnt + 1'b1;
    load = enable && cnt_next == '0;
    shift = enable && run && !load;
  end
  piso_shift_reg #(.WIDTH(FRAME)) u_piso (
    .clk  (clk),
    .rst  (rst || !enable),
    .load (load),
    .shift(shift),
    .din  ({left_data, right_data}),
    .msb  (msb)
  );
  always_ff @(posedge clk)
    if (rst || !enable) begin
      cnt <= '0;
      run <= 1'b0;
      dly <= 1'b0;
      lrclk <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      cnt <= cnt_next;
      run <= 1'b1;
      dly <= msb;
      lrclk <= cnt_next >= CW'(WIDTH);
      frame_start <= cnt_next == '0;
    end
  // I2S takes the bit one slot late, so slot 0 carries the previous frame's R LSB
  assign sd = I2S_MODE ? dly : msb;
  assign sclk = run & ~clk;
endmodule

// File: tb/tb_dac_serial_tx.sv
// tb_dac_serial_tx: directed checks of I2S and left-justified serialisation
module tb_dac_serial_tx;
  import dac_serial_tx_pkg::*;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic [23:0] left_data = '0, right_data = '0;
  logic sclk_i, lrclk_i, sd_i, fs_i, sclk_l, lrclk_l, sd_l, fs_l;
  logic [47:0] f1, f2, f4;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  dac_serial_tx #(.WIDTH(24), .I2S_MODE(bit'(I2S))) u_i2s (
    .clk(clk), .rst(rst), .enable(enable), .left_data(left_data), .right_data(right_data),
    .sclk(sclk_i), .lrclk(lrclk_i), .sd(sd_i), .frame_start(fs_i)
  );
  dac_serial_tx #(.WIDTH(24), .I2S_MODE(bit'(LEFT_JUSTIFIED))) u_lj (
    .clk(clk), .rst(rst), .enable(enable), .left_data(left_data), .right_data(right_data),
    .sclk(sclk_l), .lrclk(lrclk_l), .sd(sd_l), .frame_start(fs_l)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk(tag, {lrclk_i, sd_i, sclk_i, fs_i, lrclk_l, sd_l, sclk_l, fs_l}, 8'h00);
  endtask
  task automatic frame_check(input logic [47:0] f, input logic prev, input int first, input int last);
    logic exp_i;
    logic lr, st;
    for (int s = first; s <= last; s++) begin
      @(negedge clk);
      exp_i = prev;
      if (s > 0) exp_i = f[48-s];
      lr = s >= 24;
      st = s == 0;
      chk($sformatf("i2s_sd slot %0d", s), {7'd0, sd_i}, {7'd0, exp_i});
      chk($sformatf("lj_sd slot %0d", s), {7'd0, sd_l}, {7'd0, f[47-s]});
      chk($sformatf("ctrl slot %0d", s), {2'b00, lrclk_i, fs_i, sclk_i, lrclk_l, fs_l, sclk_l},
          {2'b00, lr, st, 1'b1, lr, st, 1'b1});
    end
  endtask
  initial begin
    repeat (3) begin
      @(negedge clk);
      chk_idle("reset");
    end
    rst = 1'b0;
    repeat (100) begin
      @(negedge clk);
      chk_idle("idle");
    end
    left_data = 24'hABCDEF;
    right_data = 24'h123456;
    f1 = {24'hABCDEF, 24'h123456};
    enable = 1'b1;
    frame_check(f1, 1'b0, 0, 10);
    left_data = 24'h800000;
    frame_check(f1, 1'b0, 11, 47);
    f2 = {24'h800000, 24'h123456};
    frame_check(f2, f1[0], 0, 47);
    frame_check(f2, f2[0], 0, 30);
    enable = 1'b0;
    @(negedge clk);
    chk_idle("abort");
    left_data = 24'h5A5A5A;
    right_data = 24'hC3C3C3;
    f4 = {24'h5A5A5A, 24'hC3C3C3};
    enable = 1'b1;
    frame_check(f4, 1'b0, 0, 47);
    frame_check(f4, f4[0], 0, 19);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("rst_priority");
    rst = 1'b0;
    frame_check(f4, 1'b0, 0, 47);
    frame_check(f4, f4[0], 0, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
